// File: rtl/dac_source_player.sv
`default_nettype none
//==============================================================================
// Module   : dac_source_player
// Purpose  : DAC channel source stage. Selects raw / external / stream source,
//            plays the host stream from a FIFO at a programmable pop rate and
//            scales the selected sample by a fade level.
// Options  : DAC_SRC_FADE_EN - when defined, every source change fades out to
//            zero and back in over 2^FADE_BITS clocks per direction; when
//            undefined the level is fixed at full scale and the selection is a
//            plain 1-clock register.
// Revision : 1.0 - initial release
//==============================================================================
module dac_source_player #(
   parameter int WIDTH      = 8,
   parameter int NSRC       = 6,
   parameter int FIFO_DEPTH = 4096,
   parameter int FADE_BITS  = 6
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NSRC*WIDTH-1:0]       src_data,
   input  logic [WIDTH-1:0]            raw,
   input  logic [$clog2(NSRC+2)-1:0]   src_sel,
   input  logic [15:0]                 rate_div,
   input  logic                        flush,
   input  logic [WIDTH-1:0]            s_data,
   input  logic                        s_valid,
   output logic                        s_ready,
   output logic [WIDTH-1:0]            dac_out,
   output logic                        dac_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [15:0]                 underrun_count,
   output logic                        fading
);

   localparam int SEL_W  = $clog2(NSRC + 2);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = FADE_BITS + 1;
   localparam int PROD_W = WIDTH + FADE_BITS + 1;
   localparam logic [SEL_W-1:0] STREAM_SEL = SEL_W'(NSRC + 1);
   localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(2 ** FADE_BITS);
   localparam logic [AW:0]      FULL_CNT   = (AW+1)'(FIFO_DEPTH);

   logic [SEL_W-1:0]  cur_sel_q;
   logic [LVL_W-1:0]  level;

   logic [15:0]       rate_cnt_q;
   logic              strobe, pop_req, empty, full, do_wr, do_pop;
   logic [WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q, count_d;
   logic [WIDTH-1:0]  stream_hold_q;
   logic [15:0]       underrun_q;

   logic [WIDTH-1:0]  samp_d, samp_q;
   logic [LVL_W-1:0]  lvl_q;
   logic signed [PROD_W-1:0] prod;
   logic [WIDTH-1:0]  dac_q;
   logic              valid_q;
   logic              unused_prod;

   // Pop strobe fires when the free-running counter reaches rate_div; the >=
   // makes a lowered rate_div take effect immediately.
   assign strobe  = rate_cnt_q >= rate_div;
   assign pop_req = strobe && (cur_sel_q == STREAM_SEL);
   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign do_wr   = s_valid && !full && !flush;
   assign do_pop  = pop_req && !empty && !flush;

   // Occupancy next-state: flush wins over any same-cycle write or pop
   always_comb begin
      count_d = count_q;
      if (flush)
         count_d = '0;
      else if (do_wr && !do_pop)
         count_d = count_q + (AW+1)'(1);
      else if (do_pop && !do_wr)
         count_d = count_q - (AW+1)'(1);
   end

   // Rate counter, FIFO pointers, held stream sample and underrun counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rate_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         stream_hold_q <= '0;
         underrun_q    <= '0;
      end else begin
         rate_cnt_q <= strobe ? 16'd0 : rate_cnt_q + 16'd1;
         count_q    <= count_d;
         if (pop_req && empty && (underrun_q != 16'hFFFF))
            underrun_q <= underrun_q + 16'd1;
         if (flush) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            stream_hold_q <= '0;
         end else begin
            if (do_wr)
               wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) begin
               rd_ptr_q      <= rd_ptr_q + AW'(1);
               stream_hold_q <= mem_q[rd_ptr_q];
            end
         end
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_wr)
         mem_q[wr_ptr_q] <= s_data;
   end

`ifdef DAC_SRC_FADE_EN
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FADE_OUT = 2'd1,
      ST_FADE_IN  = 2'd2
   } state_t;

   state_t           state_q;
   logic [LVL_W-1:0] level_q;
   logic             fading_q;
   logic             step_down;

   // Any pending change, or a fade-out already under way, walks the level down
   assign step_down = (state_q == ST_FADE_OUT) || (src_sel != cur_sel_q);

   // Fade FSM: the source switches on the clock the level lands on zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_RUN;
         level_q   <= LVL_MAX;
         cur_sel_q <= '0;
         fading_q  <= 1'b0;
      end else if (step_down) begin
         fading_q <= 1'b1;
         if (level_q <= LVL_W'(1)) begin
            level_q   <= '0;
            cur_sel_q <= src_sel;
            state_q   <= ST_FADE_IN;
         end else begin
            level_q <= level_q - LVL_W'(1);
            state_q <= ST_FADE_OUT;
         end
      end else if (state_q == ST_FADE_IN) begin
         level_q <= level_q + LVL_W'(1);
         if (level_q == LVL_MAX - LVL_W'(1)) begin
            state_q  <= ST_RUN;
            fading_q <= 1'b0;
         end
      end
   end

   assign level  = level_q;
   assign fading = fading_q;
`else
   // Without fading the selection is simply registered once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cur_sel_q <= '0;
      else
         cur_sel_q <= src_sel;
   end

   assign level  = LVL_MAX;
   assign fading = 1'b0;
`endif

   // Source mux; select codes beyond the stream give a constant zero
   always_comb begin
      samp_d = '0;
      if (cur_sel_q == '0)
         samp_d = raw;
      else if (cur_sel_q == STREAM_SEL)
         samp_d = stream_hold_q;
      else
         for (int k = 0; k < NSRC; k++)
            if (cur_sel_q == SEL_W'(k + 1))
               samp_d = src_data[k*WIDTH +: WIDTH];
   end

   // Signed sample times non-negative level; dropping FADE_BITS low bits is a
   // floor divide by full scale, so full level reproduces the sample exactly.
   assign prod = $signed({{(FADE_BITS+1){samp_q[WIDTH-1]}}, samp_q})
               * $signed({{WIDTH{1'b0}}, lvl_q});
   assign unused_prod = ^prod;

   // Two-stage data path: registered mux (with its level), then registered scale
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samp_q  <= '0;
         lvl_q   <= LVL_MAX;
         dac_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         samp_q  <= samp_d;
         lvl_q   <= level;
         dac_q   <= prod[FADE_BITS +: WIDTH];
         valid_q <= 1'b1;
      end
   end

   assign s_ready        = !full;
   assign fifo_level     = count_q;
   assign underrun_count = underrun_q;
   assign dac_out        = dac_q;
   assign dac_valid      = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_source_player.sv
`default_nettype none
//==============================================================================
// Module   : tb_dac_source_player
// Purpose  : Self-checking bench for dac_source_player (WIDTH=8, NSRC=6,
//            FIFO_DEPTH=16, FADE_BITS=2). A behavioural model predicts every
//            output each clock; literal expectations pin key sequences.
// Revision : 1.0 - initial release
//==============================================================================
module tb_dac_source_player;

   localparam int W    = 8;
   localparam int N    = 6;
   localparam int D    = 16;
   localparam int FB   = 2;
   localparam int MAX  = 1 << FB;
   localparam int STRM = N + 1;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N*W-1:0] src_data;
   logic [W-1:0]   raw;
   logic [2:0]     src_sel;
   logic [15:0]    rate_div;
   logic           flush;
   logic [W-1:0]   s_data;
   logic           s_valid;
   logic           s_ready;
   logic [W-1:0]   dac_out;
   logic           dac_valid;
   logic [4:0]     fifo_level;
   logic [15:0]    underrun_count;
   logic           fading;

   always #5 clk = ~clk;

   dac_source_player #(.WIDTH(W), .NSRC(N), .FIFO_DEPTH(D), .FADE_BITS(FB)) dut (
      .clk(clk), .reset_n(reset_n), .src_data(src_data), .raw(raw),
      .src_sel(src_sel), .rate_div(rate_div), .flush(flush), .s_data(s_data),
      .s_valid(s_valid), .s_ready(s_ready), .dac_out(dac_out),
      .dac_valid(dac_valid), .fifo_level(fifo_level),
      .underrun_count(underrun_count), .fading(fading)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   int m_cnt, m_hold, m_under, m_cur, m_lvl, m_dir, m_samp1, m_lvl1, m_dac, m_valid;
   int m_q[$];

   function automatic int src_value(input int sel);
      if (sel == 0)                return int'($signed(raw));
      if (sel >= 1 && sel <= N)    return int'($signed(src_data[(sel-1)*W +: W]));
      if (sel == STRM)             return m_hold;
      return 0;
   endfunction

   // floor(s*l / MAX) with true round-toward-minus-infinity
   function automatic int floor_scale(input int s, input int l);
      int p;
      p = s * l;
      if (p >= 0) return p / MAX;
      return -((-p + MAX - 1) / MAX);
   endfunction

   always @(posedge clk) begin : model
      bit b_strobe, b_wr, b_popreq;
      if (!reset_n) begin
         m_cnt = 0; m_hold = 0; m_under = 0; m_cur = 0; m_lvl = MAX; m_dir = 0;
         m_samp1 = 0; m_lvl1 = MAX; m_dac = 0; m_valid = 0;
         m_q.delete();
      end else begin
         b_strobe = (m_cnt >= int'(rate_div));
         m_cnt    = b_strobe ? 0 : m_cnt + 1;
         m_dac    = floor_scale(m_samp1, m_lvl1);
         m_samp1  = src_value(m_cur);
         m_lvl1   = m_lvl;
         m_valid  = 1;
         b_wr     = s_valid && (m_q.size() < D);
         b_popreq = b_strobe && (m_cur == STRM);
         if (b_popreq && m_q.size() == 0 && m_under < 65535) m_under++;
         if (flush) begin
            m_q.delete();
            m_hold = 0;
         end else begin
            if (b_popreq && m_q.size() > 0) m_hold = m_q.pop_front();
            if (b_wr) m_q.push_back(int'($signed(s_data)));
         end
`ifdef DAC_SRC_FADE_EN
         // m_dir: -1 heading to silence, +1 rising to full, 0 settled
         if (m_dir < 0 || int'(src_sel) != m_cur) begin
            if (m_lvl <= 1) begin
               m_lvl = 0; m_cur = int'(src_sel); m_dir = 1;
            end else begin
               m_lvl = m_lvl - 1; m_dir = -1;
            end
         end else if (m_dir > 0) begin
            m_lvl = m_lvl + 1;
            if (m_lvl == MAX) m_dir = 0;
         end
`else
         m_cur = int'(src_sel); m_lvl = MAX; m_dir = 0;
`endif
      end
   end

   // Every out-of-reset cycle: DUT outputs against the model
   always @(posedge clk) begin
      #1;
      if (reset_n) begin
         check("m_dac_out",   {24'd0, dac_out},        32'(m_dac) & 32'hFF);
         check("m_dac_valid", {31'd0, dac_valid},      32'(m_valid));
         check("m_fifo_lvl",  {27'd0, fifo_level},     32'(m_q.size()));
         check("m_s_ready",   {31'd0, s_ready},        32'(m_q.size() < D));
         check("m_underrun",  {16'd0, underrun_count}, 32'(m_under));
         check("m_fading",    {31'd0, fading},         32'(m_dir != 0));
      end
   end

   // ---------------- directed stimulus ----------------
`ifdef DAC_SRC_FADE_EN
   logic [7:0] exp_fade [9] = '{8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00, 8'hE0, 8'hC0, 8'hA0, 8'h80};
   logic       exp_fbit [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [7:0] exp_rev  [5] = '{8'h18, 8'h30, 8'h18, 8'h00, 8'hE0};
`else
   logic [7:0] exp_fade [9] = '{8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
   logic       exp_fbit [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [7:0] exp_rev  [5] = '{8'h60, 8'h60, 8'h80, 8'h80, 8'h80};
`endif

   initial begin
      reset_n  = 1'b0;
      src_sel  = 3'd0;
      raw      = 8'h40;
      src_data = {8'h11, 8'h22, 8'h33, 8'h44, 8'h60, 8'h80};
      rate_div = 16'd999;
      flush    = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'h00;

      // Reset values, then raw appears two clocks after release
      tick(3);
      check("rst_dac_out",   {24'd0, dac_out},   32'h0);
      check("rst_dac_valid", {31'd0, dac_valid}, 32'h0);
      check("rst_s_ready",   {31'd0, s_ready},   32'h1);
      reset_n = 1'b1;
      tick(1);
      check("rel_dac_valid", {31'd0, dac_valid}, 32'h1);
      tick(1);
      check("rel_dac_out",   {24'd0, dac_out},   32'h40);

      // Fill the FIFO; the 17th request must be refused
      for (int i = 0; i < D; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i * 3 + 1);
         tick(1);
      end
      check("full_level",   {27'd0, fifo_level}, 32'd16);
      check("full_s_ready", {31'd0, s_ready},    32'h0);
      s_data = 8'hEE;
      tick(1);
      s_valid = 1'b0;
      check("ovf_level",    {27'd0, fifo_level}, 32'd16);

      // Plain flush, then flush with a same-cycle write at level 5
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("flush_level",  {27'd0, fifo_level}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h30 + i);
         tick(1);
      end
      check("five_level",   {27'd0, fifo_level}, 32'd5);
      flush  = 1'b1;
      s_data = 8'h55;
      tick(1);
      flush   = 1'b0;
      s_valid = 1'b0;
      check("flushwr_level", {27'd0, fifo_level}, 32'd0);

      // Stream playback at one pop per 4 clocks, third pop underruns
      s_valid = 1'b1; s_data = 8'h10; tick(1);
      s_data  = 8'h20; tick(1);
      s_valid = 1'b0;
      src_sel = 3'(STRM);
      tick(14);
      check("strm_settled", {31'd0, fading},     32'h0);
      check("strm_preload", {27'd0, fifo_level}, 32'd2);
      rate_div = 16'd3;
      tick(3);
      check("strm_first",   {24'd0, dac_out},    32'h10);
      check("strm_lvl1",    {27'd0, fifo_level}, 32'd1);
      tick(4);
      check("strm_second",  {24'd0, dac_out},    32'h20);
      tick(2);
      check("strm_underrun", {16'd0, underrun_count}, 32'd1);
      tick(2);
      check("strm_hold",    {24'd0, dac_out},    32'h20);
      rate_div = 16'd999;

      // Crossfade raw 0x7F -> source 1 (0x80)
      raw     = 8'h7F;
      src_sel = 3'd0;
      tick(12);
      check("fade_start", {24'd0, dac_out}, 32'h7F);
      src_sel = 3'd1;
      tick(1);
      for (int i = 0; i < 9; i++) begin
         tick(1);
         check($sformatf("fade_out[%0d]", i), {24'd0, dac_out}, {24'd0, exp_fade[i]});
         check($sformatf("fade_flag[%0d]", i), {31'd0, fading}, {31'd0, exp_fbit[i]});
      end

      // Switch to source 2, reverse back to source 1 at fade-in level 2
      tick(4);
      src_sel = 3'd2;
      tick(6);
      src_sel = 3'd1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check($sformatf("rev_out[%0d]", i), {24'd0, dac_out}, {24'd0, exp_rev[i]});
      end

      // Reset in the middle of a fade aborts straight to reset values
      tick(6);
      src_sel = 3'd0;
      tick(3);
      reset_n = 1'b0;
      #1;
      check("mid_rst_dac",    {24'd0, dac_out},        32'h0);
      check("mid_rst_fading", {31'd0, fading},         32'h0);
      check("mid_rst_under",  {16'd0, underrun_count}, 32'h0);
      check("mid_rst_valid",  {31'd0, dac_valid},      32'h0);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      check("post_rst_dac",    {24'd0, dac_out}, 32'h7F);
      check("post_rst_fading", {31'd0, fading},  32'h0);
      tick(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
